collision_monitor: RTL

COLLISION_MONITOR -- requirements
Module: collision_monitor

---
 rtl/collision_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/collision_monitor.sv
// Pixel mux and smiley/border collision detector with per-frame edge accumulation.
// Optional hit counter output is enabled by defining COLLISION_MONITOR_HITCOUNT_EN.
module collision_monitor #(
  parameter int unsigned COOLDOWN_FRAMES    = 2,
  parameter logic [7:0]  BACKGROUND_DEFAULT = 8'h00
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       smileyDrawingRequest,
  input  logic [7:0] smileyRGB,
  input  logic [3:0] smileyHitEdgeCode,
  input  logic       bordersDrawingRequest,
  input  logic [7:0] bordersRGB,
  input  logic [7:0] backgroundRGB,
  output logic [7:0] RGBOut,
  output logic       collision,
  output logic [3:0] hitEdgeOut,
`ifdef COLLISION_MONITOR_HITCOUNT_EN
  output logic [7:0] hitCount,
`endif
  output logic [3:0] frameHitEdge
);

  localparam logic [3:0] CoolInit = 4'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    StArmed    = 2'd0,
    StHit      = 2'd1,
    StCooldown = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rgb_q, rgb_d;
  logic       collision_q, collision_d;
  logic [3:0] hit_edge_q, hit_edge_d;
  logic [3:0] frame_edge_q, frame_edge_d;
  logic [3:0] acc_q, acc_d;
  logic       overlap;

  assign overlap = smileyDrawingRequest & bordersDrawingRequest;

  always_comb begin
    rgb_d = backgroundRGB;
    if (smileyDrawingRequest) begin
      rgb_d = smileyRGB;
    end else if (bordersDrawingRequest) begin
      rgb_d = bordersRGB;
    end
  end

  // An overlap on the frame-start cycle belongs to the new frame.
  always_comb begin
    acc_d        = acc_q;
    frame_edge_d = frame_edge_q;
    if (startOfFrame) begin
      frame_edge_d = acc_q;
      acc_d        = overlap ? smileyHitEdgeCode : 4'h0;
    end else if (overlap) begin
      acc_d = acc_q | smileyHitEdgeCode;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    collision_d = 1'b0;
    hit_edge_d  = hit_edge_q;
    unique case (state_q)
      StArmed: begin
        if (overlap) begin
          collision_d = 1'b1;
          hit_edge_d  = smileyHitEdgeCode;
          state_d     = StHit;
        end
      end
      StHit: begin
        if (startOfFrame) begin
          if (CoolInit == 4'd0) begin
            state_d = StArmed;
          end else begin
            cnt_d   = CoolInit;
            state_d = StCooldown;
          end
        end
      end
      StCooldown: begin
        // Re-arm on the frame start that exhausts the count; detection resumes next cycle.
        if (startOfFrame) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = StArmed;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StArmed;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StArmed;
      cnt_q        <= 4'd0;
      rgb_q        <= BACKGROUND_DEFAULT;
      collision_q  <= 1'b0;
      hit_edge_q   <= 4'h0;
      frame_edge_q <= 4'h0;
      acc_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      collision_q  <= collision_d;
      hit_edge_q   <= hit_edge_d;
      frame_edge_q <= frame_edge_d;
      acc_q        <= acc_d;
    end
  end

  assign RGBOut       = rgb_q;
  assign collision    = collision_q;
  assign hitEdgeOut   = hit_edge_q;
  assign frameHitEdge = frame_edge_q;

`ifdef COLLISION_MONITOR_HITCOUNT_EN
  logic [7:0] hit_count_q, hit_count_d;

  // Counted alongside the pulse so hitCount updates in the same cycle collision rises.
  always_comb begin
    hit_count_d = hit_count_q;
    if (collision_d && (hit_count_q != 8'hFF)) begin
      hit_count_d = hit_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_count_q <= 8'h00;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign hitCount = hit_count_q;
`endif

endmodule
